// File: rtl/matrix_algebra_unit.sv
// Matrix store front end: four byte-addressed matrix banks loaded from / streamed to the host byte bus.
// Optional single-cycle bank clear on opcode 11 is enabled by defining MAU_BANK_CLEAR_EN.

module mau_bank #(
   parameter int N  = 64,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);
   logic [8*N-1:0] ram;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         ram <= '0;
      end else if (i_we) begin
         ram[{i_addr, 3'b000} +: 8] <= i_wdata;
      end
   end

   assign o_rdata = ram[{i_addr, 3'b000} +: 8];
endmodule

module matrix_algebra_unit #(
   parameter int matrix_dim = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] host_instruction,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       busy_flag
);
   localparam int N  = matrix_dim * matrix_dim;
   localparam int AW = $clog2(N);

`ifdef MAU_BANK_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_offset, w_offset_nxt;
   logic [7:0]    r_last, w_last_nxt;
   logic [1:0]    r_bank, w_bank_nxt;
   logic          r_busy, w_busy_nxt;
   logic [7:0]    r_data_out, w_dout_nxt;
   logic          w_clr;
   logic          w_is_nop;
   logic [1:0]    w_opcode;
   logic [3:0]    w_we;
   logic [3:0]    w_clr_bank;
   logic [7:0]    w_rdata [4];
   logic          w_b0_line_read_from_host;

   assign w_opcode = host_instruction[3:2];
   // Opcode 11 collapses onto NOP when the clear feature is not built in.
   assign w_is_nop = (w_opcode == 2'b00) || ((w_opcode == 2'b11) && !CLEAR_EN);

   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_last_nxt   = r_last;
      w_bank_nxt   = r_bank;
      w_busy_nxt   = r_busy;
      w_dout_nxt   = r_data_out;
      w_clr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_nop) begin
               w_last_nxt = '0;
            end else if (host_instruction != r_last) begin
               w_last_nxt   = host_instruction;
               w_bank_nxt   = host_instruction[7:6];
               w_offset_nxt = '0;
               case (w_opcode)
                  2'b01: begin
                     w_state_nxt = S_LOAD;
                     w_busy_nxt  = 1'b1;
                  end
                  2'b10: begin
                     w_state_nxt = S_STORE;
                     w_busy_nxt  = 1'b1;
                  end
                  default: w_clr = 1'b1;
               endcase
            end
         end
         S_LOAD, S_STORE: begin
            w_offset_nxt = r_offset + AW'(1);
            if (r_state == S_STORE) w_dout_nxt = w_rdata[r_bank];
            if (r_offset == AW'(N - 1)) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_offset   <= '0;
         r_last     <= '0;
         r_bank     <= '0;
         r_busy     <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_offset   <= w_offset_nxt;
         r_last     <= w_last_nxt;
         r_bank     <= w_bank_nxt;
         r_busy     <= w_busy_nxt;
         r_data_out <= w_dout_nxt;
      end
   end

   assign w_b0_line_read_from_host = (r_state == S_LOAD) && (r_bank == 2'd0);

   always_comb begin
      w_we    = '0;
      w_we[0] = w_b0_line_read_from_host;
      for (int i = 1; i < 4; i++) begin
         w_we[i] = (r_state == S_LOAD) && (r_bank == 2'(i));
      end
      // Clear targets the bank named by the instruction on its accept edge.
      for (int i = 0; i < 4; i++) begin
         w_clr_bank[i] = w_clr && (host_instruction[7:6] == 2'(i));
      end
   end

   mau_bank #(.N(N), .AW(AW)) B0 (.clk(clk), .rst(rst), .i_clr(w_clr_bank[0]), .i_we(w_we[0]),
                                  .i_addr(r_offset), .i_wdata(data_in), .o_rdata(w_rdata[0]));
   mau_bank #(.N(N), .AW(AW)) B1 (.clk(clk), .rst(rst), .i_clr(w_clr_bank[1]), .i_we(w_we[1]),
                                  .i_addr(r_offset), .i_wdata(data_in), .o_rdata(w_rdata[1]));
   mau_bank #(.N(N), .AW(AW)) B2 (.clk(clk), .rst(rst), .i_clr(w_clr_bank[2]), .i_we(w_we[2]),
                                  .i_addr(r_offset), .i_wdata(data_in), .o_rdata(w_rdata[2]));
   mau_bank #(.N(N), .AW(AW)) B3 (.clk(clk), .rst(rst), .i_clr(w_clr_bank[3]), .i_we(w_we[3]),
                                  .i_addr(r_offset), .i_wdata(data_in), .o_rdata(w_rdata[3]));

   assign data_out  = r_data_out;
   assign busy_flag = r_busy;
endmodule

// File: tb/tb_matrix_algebra_unit.sv
// Scoreboard bench for matrix_algebra_unit: bank model updated on LOAD, expected STORE bytes queued.
// Honours MAU_BANK_CLEAR_EN when the design is built with it.

module tb_matrix_algebra_unit;
   localparam int N = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] host_instruction;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       busy_flag;

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] m [4][N];
   logic [7:0] sb_q [$];

   always #5 clk = ~clk;

   matrix_algebra_unit #(.matrix_dim(8)) dut (
      .clk(clk),
      .rst(rst),
      .host_instruction(host_instruction),
      .data_in(data_in),
      .data_out(data_out),
      .busy_flag(busy_flag)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] pack(input int b);
      logic [511:0] v;
      for (int k = 0; k < N; k++) v[8*k +: 8] = m[b][k];
      return v;
   endfunction

   function automatic logic [511:0] bank_ram(input int b);
      case (b)
         0:       return dut.B0.ram;
         1:       return dut.B1.ram;
         2:       return dut.B2.ram;
         default: return dut.B3.ram;
      endcase
   endfunction

   function automatic logic [7:0] pat_val(input int pat, input int k);
      case (pat)
         0:       return 8'h41;
         1:       return 8'(k);
         2:       return 8'(k) ^ 8'hA5;
         default: return 8'(3 * k + 1);
      endcase
   endfunction

   task automatic check_banks(input string tag);
      for (int b = 0; b < 4; b++) check($sformatf("%s_B%0d", tag, b), bank_ram(b), pack(b));
   endtask

   task automatic zero_model();
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < N; k++) m[b][k] = 8'h00;
   endtask

   task automatic wait_accept(input int max_lat, input string tag);
      int w;
      w = 0;
      do begin
         step();
         w++;
      end while (!busy_flag && w < 8);
      check(tag, 512'(w <= max_lat && busy_flag), 512'd1);
   endtask

   task automatic run_load(input logic [7:0] instr, input int bank, input int pat);
      int k;
      host_instruction = instr;
      wait_accept(2, "load_accept");
      k = 0;
      while (busy_flag && k < 100) begin
         data_in = pat_val(pat, k);
         if (k < N) m[bank][k] = data_in;
         step();
         k++;
      end
      check("load_busy_len", 512'(k), 512'(N));
      repeat (3) step();
      check("held_no_retrig", 512'(busy_flag), 512'd0);
   endtask

   task automatic run_store(input logic [7:0] instr, input int bank);
      int nb;
      host_instruction = instr;
      for (int k = 0; k < N; k++) sb_q.push_back(m[bank][k]);
      wait_accept(2, "store_accept");
      nb = 1;
      for (int i = 0; i < N; i++) begin
         step();
         if (sb_q.size() > 0) check($sformatf("store_dout_%0d", i), 512'(data_out), 512'(sb_q.pop_front()));
         else check("store_q_empty", 512'd1, 512'd0);
         if (busy_flag) nb++;
      end
      check("store_busy_len", 512'(nb), 512'(N));
      repeat (2) step();
      check("store_dout_hold", 512'(data_out), 512'(m[bank][N-1]));
   endtask

   initial begin
      rst = 1'b1;
      host_instruction = 8'h00;
      data_in = 8'h00;
      zero_model();
      step();
      rst = 1'b0;
      check("rst_busy", 512'(busy_flag), 512'd0);
      check("rst_dout", 512'(data_out), 512'd0);
      check_banks("rst");
      repeat (2) step();
      check("nop_busy", 512'(busy_flag), 512'd0);

      run_load(8'h04, 0, 0);
      check_banks("loadB0");

      host_instruction = 8'h0C;
      step();
      check("clr_b0_busy", 512'(busy_flag), 512'd0);
`ifdef MAU_BANK_CLEAR_EN
      for (int k = 0; k < N; k++) m[0][k] = 8'h00;
`endif
      run_load(8'h44, 1, 1);
      check_banks("loadB1");

      run_load(8'h84, 2, 2);
      run_load(8'hC4, 3, 3);
      check_banks("loadB23");

      run_store(8'h48, 1);
      check_banks("store");

      host_instruction = 8'h00;
      step();
      host_instruction = 8'h04;
      wait_accept(2, "rst_load_accept");
      for (int i = 0; i < 10; i++) begin
         data_in = 8'hEE;
         step();
      end
      host_instruction = 8'h00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      zero_model();
      check("midrst_busy", 512'(busy_flag), 512'd0);
      check_banks("midrst");
      step();
      check("midrst_idle", 512'(busy_flag), 512'd0);

`ifdef MAU_BANK_CLEAR_EN
      begin
         int nb;
         run_load(8'h44, 1, 1);
         host_instruction = 8'h4C;
         nb = 0;
         repeat (3) begin
            step();
            if (busy_flag) nb++;
         end
         for (int k = 0; k < N; k++) m[1][k] = 8'h00;
         check("clr_busy", 512'(nb), 512'd0);
         check_banks("clrB1");
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
